// File: rtl/usb_rx_data_buffer_if.sv
// Byte-stream and reader signals between usb_rx, the rx data buffer and the endpoint-side reader.
interface usb_rx_data_buffer_if #(
  parameter int ADDR_W = 6
);
  logic              store_rx_packet;
  logic [7:0]        rx_packet_data;
  logic              packet_done;
  logic              r_error;
  logic              get_rx_data;
  logic              flush;
  logic [7:0]        rx_data;
  logic [ADDR_W:0]   buffer_occupancy;
  logic              rx_data_valid;
  logic              overflow;

  modport master (
    output store_rx_packet, rx_packet_data, packet_done, r_error, get_rx_data, flush,
    input  rx_data, buffer_occupancy, rx_data_valid, overflow
  );

  modport slave (
    input  store_rx_packet, rx_packet_data, packet_done, r_error, get_rx_data, flush,
    output rx_data, buffer_occupancy, rx_data_valid, overflow
  );
endinterface

// File: rtl/usb_rx_data_buffer.sv
// Packet-aware byte FIFO: bytes stay pending until packet_done commits them or r_error
// rolls the write pointer back to the commit boundary.
module usb_rx_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  usb_rx_data_buffer_if.slave bus
);
  localparam int CW = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rptr, cptr, wptr;
  logic [ADDR_W-1:0] rptr_n, cptr_n, wptr_n;
  logic [CW-1:0]     c_cnt, p_cnt, c_cnt_n, p_cnt_n;
  logic              ovf, ovf_n;
  logic              full, do_store, do_pop;
  logic [CW:0]       used;

  // Full/empty come from the counters only; pointers alias when wrapped.
  assign used     = {1'b0, c_cnt} + {1'b0, p_cnt};
  assign full     = (used == (CW+1)'(DEPTH));
  assign do_store = bus.store_rx_packet && !full;
  assign do_pop   = bus.get_rx_data && (c_cnt != '0);

  always_comb begin
    rptr_n  = rptr + ADDR_W'(do_pop);
    cptr_n  = cptr;
    wptr_n  = wptr + ADDR_W'(do_store);
    c_cnt_n = c_cnt - CW'(do_pop);
    p_cnt_n = p_cnt + CW'(do_store);
    ovf_n   = ovf | (bus.store_rx_packet && full);
    if (bus.r_error) begin
      wptr_n  = cptr;
      p_cnt_n = '0;
    end else if (bus.packet_done) begin
      // A store in the commit cycle is folded into the packet.
      cptr_n  = wptr + ADDR_W'(do_store);
      c_cnt_n = c_cnt - CW'(do_pop) + p_cnt + CW'(do_store);
      p_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst || bus.flush) begin
      rptr  <= '0;
      cptr  <= '0;
      wptr  <= '0;
      c_cnt <= '0;
      p_cnt <= '0;
      ovf   <= 1'b0;
    end else begin
      rptr  <= rptr_n;
      cptr  <= cptr_n;
      wptr  <= wptr_n;
      c_cnt <= c_cnt_n;
      p_cnt <= p_cnt_n;
      ovf   <= ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst && !bus.flush && do_store)
      mem[wptr] <= bus.rx_packet_data;
  end

  assign bus.rx_data          = (c_cnt != '0) ? mem[rptr] : 8'h00;
  assign bus.buffer_occupancy = c_cnt;
  assign bus.rx_data_valid    = (c_cnt != '0);
  assign bus.overflow         = ovf;
endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Directed + randomized bench for usb_rx_data_buffer against a queue-based packet model.
module tb_usb_rx_data_buffer;
  localparam int DEPTH = 64;

  logic tb_clk = 1'b0;
  logic tb_n_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  usb_rx_data_buffer_if #(.ADDR_W(6)) bus ();

  usb_rx_data_buffer #(.DEPTH(DEPTH), .ADDR_W(6)) dut (
    .clk   (tb_clk),
    .n_rst (tb_n_rst),
    .bus   (bus)
  );

  always #5 tb_clk = ~tb_clk;

  // Model: committed bytes, pending bytes, sticky overflow.
  logic [7:0] cq [$];
  logic [7:0] pq [$];
  bit         m_ovf;

  always @(posedge tb_clk) begin
    int pre_c;
    bit was_full;
    if (tb_n_rst || bus.flush) begin
      cq.delete();
      pq.delete();
      m_ovf = 1'b0;
    end else begin
      pre_c    = cq.size();
      was_full = (cq.size() + pq.size()) == DEPTH;
      if (bus.store_rx_packet) begin
        if (was_full) m_ovf = 1'b1;
        else          pq.push_back(bus.rx_packet_data);
      end
      if (bus.get_rx_data && pre_c > 0) void'(cq.pop_front());
      if (bus.r_error) pq.delete();
      else if (bus.packet_done) begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
      end
    end
  end

  function automatic int m_head();
    return (cq.size() > 0) ? int'(cq[0]) : 0;
  endfunction

  always @(negedge tb_clk) begin
    if (chk_en) begin
      checks++;
      if (bus.buffer_occupancy != 7'(cq.size()) || bus.rx_data != 8'(m_head()) ||
          bus.rx_data_valid != (cq.size() > 0) || bus.overflow != m_ovf) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t occ=%0d/%0d data=%02h/%02h vld=%0d ovf=%0d/%0d",
                 $time, bus.buffer_occupancy, cq.size(), bus.rx_data, m_head(),
                 bus.rx_data_valid, bus.overflow, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pins DUT and model to hand-computed values.
  task automatic lit(input string name, input int occ, input int data, input int ovf);
    chk({name, "_occ"},       int'(bus.buffer_occupancy), occ);
    chk({name, "_data"},      int'(bus.rx_data), data);
    chk({name, "_ovf"},       int'(bus.overflow), ovf);
    chk({name, "_model_occ"}, cq.size(), occ);
    chk({name, "_model_dat"}, m_head(), data);
  endtask

  task automatic cyc(input bit st, input logic [7:0] d, input bit pd, input bit re,
                     input bit gt, input bit fl);
    bus.store_rx_packet = st;
    bus.rx_packet_data  = d;
    bus.packet_done     = pd;
    bus.r_error         = re;
    bus.get_rx_data     = gt;
    bus.flush           = fl;
    @(posedge tb_clk);
    #1;
    bus.store_rx_packet = 1'b0;
    bus.packet_done     = 1'b0;
    bus.r_error         = 1'b0;
    bus.get_rx_data     = 1'b0;
    bus.flush           = 1'b0;
  endtask

  task automatic store(input logic [7:0] d); cyc(1, d, 0, 0, 0, 0); endtask
  task automatic commit();                   cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic pop();                      cyc(0, 0, 0, 0, 1, 0); endtask

  task automatic do_reset(input int n);
    tb_n_rst = 1'b1;
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
    tb_n_rst = 1'b0;
  endtask

  initial begin
    bus.store_rx_packet = 0; bus.rx_packet_data = 0; bus.packet_done = 0;
    bus.r_error = 0; bus.get_rx_data = 0; bus.flush = 0;
    do_reset(2);
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);
    chk("reset_valid", int'(bus.rx_data_valid), 0);

    // Nominal packet
    store(8'h01); store(8'h02); store(8'h03);
    lit("pending", 0, 0, 0);
    commit();
    lit("commit3", 3, 8'h01, 0);
    pop(); lit("pop1", 2, 8'h02, 0);
    pop(); lit("pop2", 1, 8'h03, 0);
    pop(); lit("pop3", 0, 8'h00, 0);
    pop(); lit("pop_empty", 0, 8'h00, 0);

    // Error discard
    store(8'hAA); store(8'hBB); commit();
    store(8'h10); store(8'h11); store(8'h12);
    cyc(0, 0, 0, 1, 0, 0);
    lit("discard", 2, 8'hAA, 0);
    store(8'hCC); commit();
    lit("after_cc", 3, 8'hAA, 0);
    pop(); lit("rd_bb", 2, 8'hBB, 0);
    pop(); lit("rd_cc", 1, 8'hCC, 0);
    pop();

    // Overflow, drop under simultaneous pop, and wrap order
    for (int i = 0; i < DEPTH; i++) store(8'(i));
    commit();
    lit("full", 64, 8'h00, 0);
    store(8'h55);
    lit("ovf", 64, 8'h00, 1);
    cyc(1, 8'h66, 0, 0, 1, 0);
    lit("pop_store_full", 63, 8'h01, 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("wrap_order", int'(bus.rx_data), i);
      pop();
    end
    commit();
    lit("dropped", 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    lit("flush", 0, 0, 0);

    // Store + commit + pop in one cycle
    store(8'h10); commit(); store(8'h20);
    cyc(1, 8'h77, 1, 0, 1, 0);
    lit("simul", 2, 8'h20, 0);
    pop(); lit("simul_b", 1, 8'h77, 0);
    pop();

    // Precedence: r_error beats store and packet_done
    cyc(1, 8'h99, 0, 1, 0, 0);
    commit();
    lit("st_re", 0, 0, 0);
    store(8'h11);
    cyc(1, 8'h22, 1, 1, 0, 0);
    lit("pd_re", 0, 0, 0);
    commit();
    lit("pd_re_clear", 0, 0, 0);

    // Randomized traffic with a mid-activity reset
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        do_reset(2);
        lit("mid_reset", 0, 0, 0);
      end
      cyc($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 40,
          $urandom_range(0, 599) == 0);
    end

    @(negedge tb_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_rx_data_buffer.md
Name: usb_rx_data_buffer

Overview:
- Packet-aware byte FIFO directly downstream of usb_rx.
- Accepts decoded payload bytes on store_rx_packet/rx_packet_data and holds them as pending until usb_rx signals packet_done (commit) or r_error (discard).
- Only committed bytes are visible to the endpoint/host-side reader, which pops them via get_rx_data.

Parameters:
- DEPTH, 64, number of byte entries; power of two.
- ADDR_W, 6, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  synchronous, active-high reset; 1 at a rising clk edge resets all state.
- store_rx_packet  in  1  one-cycle strobe from usb_rx: write rx_packet_data as a pending byte.
- rx_packet_data  in  8  payload byte from usb_rx.
- packet_done  in  1  one-cycle strobe from usb_rx: commit all pending bytes.
- r_error  in  1  one-cycle strobe from usb_rx: discard all pending bytes.
- get_rx_data  in  1  reader pop request; one byte per asserted cycle.
- flush  in  1  synchronous clear of all contents and flags.
- rx_data  out  8  byte at head of committed data (first-word fall-through).
- buffer_occupancy  out  ADDR_W+1  count of committed bytes, 0..DEPTH.
- rx_data_valid  out  1  buffer_occupancy != 0.
- overflow  out  1  sticky: a store was dropped because storage was full.

Behaviour:
- Storage: DEPTH x 8 register array.
- Pointers:
  - rptr (read head), cptr (commit boundary), wptr (write, including pending).
  - All are ADDR_W bits, wrapping modulo DEPTH.
- Counters:
  - committed count C, 0..DEPTH.
  - pending count P, 0..DEPTH.
  - C+P never exceeds DEPTH.
- Reset (n_rst=1): pointers=0, C=0, P=0, overflow=0. Outputs: rx_data=0, buffer_occupancy=0, rx_data_valid=0.
- rx_data = mem[rptr] when C>0, else 8'h00. Combinational from registered state; zero latency to the head byte.
- buffer_occupancy = C. Pending bytes are never counted.
- Store: on store_rx_packet with C+P<DEPTH, write mem[wptr], then wptr++ and P++.
- Store when full: on store_rx_packet with C+P==DEPTH, byte dropped, pointers unchanged, overflow<=1.
- Pop:
  - On get_rx_data with C>0: rptr++, C--.
  - On get_rx_data with C==0: ignored, no state change, no error flag.
- Commit: on packet_done, cptr<=wptr, C<=C+P, P<=0. Commit with P==0 is a no-op.
- Discard: on r_error, wptr<=cptr, P<=0. Committed data and rptr are untouched.
- Priority per cycle: n_rst > flush > r_error > packet_done. Store and pop are evaluated together with commit/discard.
- flush: same effect as reset on pointers, counters and overflow. Memory contents need not be cleared.
- Simultaneous events:
  - store + packet_done: the byte is written and included in the commit, so C gains P+1 (if space existed).
  - store + r_error: the byte is discarded along with all pending bytes; wptr<=cptr.
  - packet_done + r_error: r_error wins; no commit.
  - pop + commit: new C = C - 1 + P(+1 if store). The pop is legal only if the pre-cycle C>0.
  - pop + store when C+P==DEPTH: the store is still dropped. Full is judged on pre-cycle state; the slot freed this cycle is not usable until the next cycle.
- Wrap-around: all pointers wrap from DEPTH-1 to 0. Full and empty are determined only by the counters, never by pointer compare.
- overflow clears only on n_rst or flush. A packet that overflowed may still be committed; the dropped bytes are simply absent.
- rx_packet (PID) is not consumed here; PID handling stays in the protocol controller.
- RTL must be synthesizable with no latches; memory is written only on accepted stores.

Test Plan:
- Reset: assert n_rst 2 cycles mid-activity -> buffer_occupancy=0, rx_data_valid=0, rx_data=8'h00, overflow=0.
- Nominal packet: store 8'h01, 8'h02, 8'h03, then packet_done.
  - Before packet_done: buffer_occupancy=0 while pending.
  - After packet_done: buffer_occupancy=3, rx_data=8'h01.
  - Pops yield 02, 03, then occupancy=0 and rx_data=00.
- Error discard: commit 2 bytes (AA, BB), store 3 more, pulse r_error -> occupancy=2. Next packet 8'hCC + packet_done -> read order AA, BB, CC.
- Overflow: 64 stores + packet_done, then store 8'h55 -> overflow=1, occupancy=64, byte dropped.
  - Pop all 64 and check wrap order.
  - flush -> overflow=0.
- Simultaneous: with occupancy=1 and P=1, drive store 8'h77 + packet_done + get_rx_data in one cycle -> occupancy=2, head is the old pending byte.
- Precedence: store + r_error in the same cycle -> nothing added. packet_done + r_error in the same cycle -> occupancy unchanged, pending cleared.
